// File: rtl/store_trace_monitor.sv
// Passive store tracer for the polirv memory bus: captures data stores into a
// FWFT FIFO and flags a halted core. Optional STORE_TRACE_DEDUP_EN drops repeated stores.
module store_trace_monitor #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 64,
  parameter int HALT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     d_mem_we,
  input  logic [ADDR_W-1:0]        d_mem_addr,
  input  logic [DATA_W-1:0]        d_mem_data,
  input  logic [ADDR_W-1:0]        i_mem_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [ADDR_W-1:0]        out_iaddr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HALT_CYCLES + 1);

  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [ADDR_W-1:0] mem_iaddr [DEPTH];

  logic [PW-1:0]     rptr, wptr;
  logic [ADDR_W-1:0] prev_iaddr;
  logic [HW-1:0]     stab;

  logic full, pop, push_req, push;

`ifdef STORE_TRACE_DEDUP_EN
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  logic              last_vld;
  logic              dup;

  assign dup      = last_vld && (last_addr == d_mem_addr) && (last_data == d_mem_data);
  assign push_req = d_mem_we && !dup;

  // Remembers the last entry actually written; dropped stores do not update it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr <= '0;
      last_data <= '0;
      last_vld  <= 1'b0;
    end else if (push) begin
      last_addr <= d_mem_addr;
      last_data <= d_mem_data;
      last_vld  <= 1'b1;
    end
  end
`else
  assign push_req = d_mem_we;
`endif

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign push      = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr]  <= d_mem_addr;
      mem_data[wptr]  <= d_mem_data;
      mem_iaddr[wptr] <= i_mem_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  assign out_addr  = out_valid ? mem_addr[rptr]  : '0;
  assign out_data  = out_valid ? mem_data[rptr]  : '0;
  assign out_iaddr = out_valid ? mem_iaddr[rptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_iaddr <= '0;
      stab       <= '0;
    end else begin
      prev_iaddr <= i_mem_addr;
      if (i_mem_addr != prev_iaddr) stab <= '0;
      else if (stab != HW'(HALT_CYCLES)) stab <= stab + HW'(1);
    end
  end

  assign halted = (stab == HW'(HALT_CYCLES));

endmodule

// File: tb/tb_store_trace_monitor.sv
// Directed bench for store_trace_monitor with a queue scoreboard of expected FIFO entries.
module tb_store_trace_monitor;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_mem_we = 1'b0;
  logic [5:0]  d_mem_addr = '0;
  logic [63:0] d_mem_data = '0;
  logic [5:0]  i_mem_addr = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [5:0]  out_addr, out_iaddr;
  logic [63:0] out_data;
  logic [3:0]  count;
  logic        overflow, halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  a;
    logic [63:0] d;
    logic [5:0]  ia;
  } ent_t;

  ent_t        q[$];
  logic        ovf_m = 1'b0;
  logic        last_v = 1'b0;
  logic [5:0]  last_a = '0;
  logic [63:0] last_d = '0;

  store_trace_monitor #(.DEPTH(DEPTH), .ADDR_W(6), .DATA_W(64), .HALT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr),
    .d_mem_data(d_mem_data), .i_mem_addr(i_mem_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_iaddr(out_iaddr), .count(count), .overflow(overflow), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m  = 1'b0;
    last_v = 1'b0;
  endtask

  // Drive one cycle at the falling edge, check the head, advance, then check occupancy.
  task automatic step(input logic we, input logic [5:0] a, input logic [63:0] d,
                      input logic [5:0] ia, input logic rdy);
    ent_t e;
    logic pop, att;
    d_mem_we = we; d_mem_addr = a; d_mem_data = d; i_mem_addr = ia; out_ready = rdy;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_addr",  64'(out_addr),  64'(q[0].a));
      chk("head_data",  out_data,       q[0].d);
      chk("head_iaddr", 64'(out_iaddr), 64'(q[0].ia));
    end else begin
      chk("idle_head", {out_data ^ 64'(out_addr) ^ 64'(out_iaddr)}, 64'd0);
    end
    pop = (q.size() != 0) && rdy;
    att = we;
`ifdef STORE_TRACE_DEDUP_EN
    if (last_v && last_a == a && last_d == d) att = 1'b0;
`endif
    if (pop) void'(q.pop_front());
    if (att) begin
      if (q.size() < DEPTH) begin
        e.a = a; e.d = d; e.ia = ia;
        q.push_back(e);
        last_v = 1'b1; last_a = a; last_d = d;
      end else ovf_m = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("count",    64'(count),    64'(q.size()));
    chk("overflow", 64'(overflow), 64'(ovf_m));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_head"}, out_data | 64'(out_addr) | 64'(out_iaddr), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
  endtask

  initial begin
    // Reset held for 3 cycles while the store strobe toggles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d_mem_we = ~d_mem_we; d_mem_addr = 6'(i + 1); d_mem_data = 64'(i + 100);
    end
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    d_mem_we = 1'b0;
    model_reset();

    // Single store then pop.
    step(1'b1, 6'd5, 64'h0000_0000_DEAD_BEEF, 6'd12, 1'b0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_addr", 64'(out_addr), 64'd5);
    step(1'b0, 6'd0, 64'd0, 6'd12, 1'b1);
    chk("single_drained", 64'(count), 64'd0);

    // Fill past capacity; the ninth store is dropped.
    for (int i = 0; i < 9; i++) step(1'b1, 6'(i), 64'h100 + 64'(i), 6'(i + 20), 1'b0);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_ovf", 64'(overflow), 64'd1);

    // Full with simultaneous push/pop: nothing dropped, occupancy unchanged.
    step(1'b1, 6'd20, 64'h2020, 6'd33, 1'b1);
    chk("pushpop_count", 64'(count), 64'd8);

    // Drain; scoreboard verifies order 1..7 then 20.
    for (int i = 0; i < 8; i++) step(1'b0, 6'd0, 64'd0, 6'd33, 1'b1);
    step(1'b0, 6'd0, 64'd0, 6'd33, 1'b0);

    // Halt detection: fetch advances to 40 then holds.
    for (int i = 0; i < 10; i++) step(1'b0, 6'd0, 64'd0, 6'(31 + i), 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 6'd0, 64'd0, 6'd40, 1'b0);
      chk($sformatf("halt_edge%0d", k), 64'(halted), 64'(k == 16));
    end
    step(1'b1, 6'd9, 64'h99, 6'd40, 1'b0);
    chk("halt_capture", 64'(halted), 64'd1);
    step(1'b0, 6'd0, 64'd0, 6'd41, 1'b1);
    chk("halt_release", 64'(halted), 64'd0);

    // Repeated identical stores.
    for (int i = 0; i < 3; i++) step(1'b1, 6'd3, 64'd7, 6'd50, 1'b0);
    step(1'b1, 6'd3, 64'd8, 6'd51, 1'b0);
`ifdef STORE_TRACE_DEDUP_EN
    chk("dedup_count", 64'(count), 64'd2);
`else
    chk("dedup_count", 64'(count), 64'd4);
`endif

    // Mid-operation reset discards contents and sticky overflow at once.
    rst = 1'b1;
    d_mem_we = 1'b1;
    #1;
    chk_reset_state("midrst_async");
    @(posedge clk);
    @(negedge clk);
    chk("midrst_store_ignored", 64'(count), 64'd0);
    rst = 1'b0;
    d_mem_we = 1'b0;
    model_reset();
    step(1'b1, 6'd17, 64'h1717, 6'd2, 1'b0);
    step(1'b0, 6'd0, 64'd0, 6'd2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_trace_monitor.md
# store_trace_monitor

Passive observer on the `polirv` core's memory-side bus, sitting between the core and the external `memoria` model in the simulation top. It captures every data-memory store (address, data, fetch address) into a first-word-fall-through FIFO drained by a valid/ready reader. It also flags a halted core when the instruction fetch address stops advancing. The bench uses it to check architectural results without probing core internals.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `ADDR_W`, 6, width of instruction and data addresses
- `DATA_W`, 64, store data width
- `HALT_CYCLES`, 16, consecutive unchanged-fetch cycles that declare a halt; ≥2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `d_mem_we`  in  1  core store strobe, sampled every rising edge
- `d_mem_addr`  in  ADDR_W  store address
- `d_mem_data`  in  DATA_W  store data
- `i_mem_addr`  in  ADDR_W  core fetch address
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  reader accepts head
- `out_addr`  out  ADDR_W  head store address
- `out_data`  out  DATA_W  head store data
- `out_iaddr`  out  ADDR_W  fetch address sampled in the store's cycle
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: a store was dropped because the FIFO was full
- `halted`  out  1  fetch address has been stable for HALT_CYCLES

## Operation
- Push condition: `d_mem_we`=1 at a rising edge. Entry = {d_mem_addr, d_mem_data, i_mem_addr}.
- Pop condition: `out_valid && out_ready` at a rising edge.
- `out_valid` = (count != 0). Head fields are driven from the read pointer. When `out_valid`=0, all head fields are forced to 0.
- Empty, push: entry visible with `out_valid`=1 after that edge (1-cycle latency).
- Full, push, no pop: the entry is dropped, `overflow` is set, and count stays at DEPTH.
- Full, push and pop together: both occur, count is unchanged, and nothing is dropped.
- Empty, pop attempt: impossible because `out_valid`=0. A push in the same cycle proceeds normally.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is tracked separately and is never derived from pointer difference alone.
- `overflow` is cleared only by `rst`.
- Halt detector:
  - A register holds the previous `i_mem_addr`, together with a saturating stability counter.
  - Each edge: if `i_mem_addr` equals the previous value, the counter increments (saturating at HALT_CYCLES); otherwise the counter clears to 0.
  - `halted` = 1 while counter == HALT_CYCLES. It falls on the edge after the fetch address changes.
- Stores continue to be captured while `halted`=1.

## Timing
- All state is registered on `clk` rising edge and cleared asynchronously by `rst`.
- Reset values:
  - outputs: `out_valid`=0, `out_addr`/`out_data`/`out_iaddr`=0, `count`=0, `overflow`=0, `halted`=0
  - internal: pointers 0, previous-fetch register 0, stability counter 0
- Reset mid-operation: all FIFO contents are discarded immediately. Stores presented while `rst`=1 are ignored.
- Push-to-head latency: 1 cycle. Pop takes effect at the edge; the next head is visible in the following cycle.
- Halt latency: `halted` rises HALT_CYCLES edges after the last fetch-address change. Example with HALT_CYCLES=16: the address changes at edge 0 and is held, so `halted` rises after edge 16.
- No combinational path from inputs to outputs except `out_ready`-independent head muxing. `out_valid` never depends on `out_ready`.

## Configuration
- `STORE_TRACE_DEDUP_EN`: defined, a push is suppressed when {d_mem_addr, d_mem_data} equals the last pushed entry.
  - The last-pushed register and its valid flag clear on reset.
  - Suppressed duplicates do not set `overflow` and do not affect count.
  - A duplicate that arrives while the FIFO is full is suppressed, not counted as overflow.
- Undefined: every store strobe is a push attempt, including identical repeats.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `d_mem_we` toggling -> count=0, `out_valid`=0, all head fields 0, `overflow`=0, `halted`=0.
- Single store: we=1 for one cycle with addr=5, data=0x0000_0000_DEAD_BEEF, i_mem_addr=12 -> next cycle `out_valid`=1 with fields 5/0xDEADBEEF/12; out_ready=1 for one cycle -> count=0.
- Fill and overflow: 9 stores to addr 0..8 with out_ready=0 and DEPTH=8 -> count=8, `overflow`=1. Draining yields addr 0..7 in order; addr 8 is absent.
- Full with simultaneous push/pop: FIFO full, push addr=20 with out_ready=1 -> count stays 8, `overflow` unchanged, and addr 20 emerges last.
- Halt: i_mem_addr increments for 10 cycles, then holds at 40 -> `halted`=1 exactly 16 edges after the hold begins; changing to 41 -> `halted`=0 after the next edge.
- Dedup (macro defined): three stores addr=3, data=7 -> count=1. A fourth store addr=3, data=8 -> count=2. With the macro undefined, the same stimulus -> count=4.
